// File: rtl/pipeline_latch_ctrl.sv
// pipeline_latch_ctrl
//   Central sequencer for the four inter-stage latches of the 5-stage pipe:
//   IF/ID (0), ID/EX (1), EX/MEM (2), MEM/WB (3). Every cycle it decides, for
//   each latch, whether it loads (en) or clears to a NOP (flush). It also
//   tracks a valid bit per latch and owns the PC update enable.
//
//   Ports:
//     CLK, nRST      clock (rising edge), async active-low reset
//     ihit, dhit     fetch / data-memory access complete this cycle
//     dmem_req       EX/MEM holds a load or store
//     load_use       ID reads the destination of a load sitting in ID/EX
//     branch_taken   EX resolved a taken branch/jump
//     halt_wb        MEM/WB holds a halt
//     en, flush      per-latch load enable / clear-to-NOP (flush wins)
//     pc_en          PC update enable
//     stage_valid    registered valid bit per latch
//     halted         sticky halt indicator
//
//   Optional build macro PIPE_CTRL_PERF_EN adds the saturating counters
//   stall_cycles and flush_count.

// Valid bit for one latch: cleared by flush, loaded from the upstream valid
// when the latch is enabled, otherwise held.
module pipeline_latch_valid (
    input  logic CLK,
    input  logic nRST,
    input  logic en_i,
    input  logic flush_i,
    input  logic src_i,
    output logic valid_o
);
    logic valid_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        valid_q <= 1'b0;
        else if (flush_i) valid_q <= 1'b0;
        else if (en_i)    valid_q <= src_i;
    end

    assign valid_o = valid_q;
endmodule

module pipeline_latch_ctrl #(
    parameter int NUM_LATCHES    = 4,
    parameter int BR_FLUSH_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dmem_req,
    input  logic                   load_use,
    input  logic                   branch_taken,
    input  logic                   halt_wb,
    output logic [NUM_LATCHES-1:0] en,
    output logic [NUM_LATCHES-1:0] flush,
    output logic                   pc_en,
    output logic [NUM_LATCHES-1:0] stage_valid,
    output logic                   halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_count
`endif
);

    generate
        if (NUM_LATCHES != 4) begin : g_bad_num_latches
            $error("pipeline_latch_ctrl: NUM_LATCHES must be 4");
        end
        if (BR_FLUSH_DEPTH < 1 || BR_FLUSH_DEPTH > 3) begin : g_bad_br_depth
            $error("pipeline_latch_ctrl: BR_FLUSH_DEPTH must be 1..3");
        end
    endgenerate

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e state_q;
    logic   halted_q;

    // Hazard inputs only count when the latch they describe holds real work.
    logic dreq_v, lu_v, br_v, halt_v;
    assign dreq_v = dmem_req     & stage_valid[2];
    assign lu_v   = load_use     & stage_valid[1];
    assign br_v   = branch_taken & stage_valid[1];
    assign halt_v = halt_wb      & stage_valid[3];

    // Freeze covers the first miss cycle (still in RUN) as well as DWAIT; the
    // cycle dhit arrives is already free to advance.
    logic freeze, run_or_wait, br_take, lu_take;
    assign run_or_wait = (state_q == RUN) || (state_q == DWAIT);
    assign freeze  = ((state_q == DWAIT) && !dhit) ||
                     ((state_q == RUN) && dreq_v && !dhit);
    assign br_take = run_or_wait && !freeze && br_v;
    assign lu_take = run_or_wait && !freeze && !br_v && lu_v;

    always_comb begin
        en    = '0;
        flush = '0;
        pc_en = 1'b0;
        if (!nRST || !run_or_wait || freeze) begin
            // everything held
        end else if (br_take) begin
            en    = '1;
            for (int i = 0; i < BR_FLUSH_DEPTH; i++) flush[i] = 1'b1;
            pc_en = 1'b1;
        end else if (lu_take) begin
            en       = '1;
            en[0]    = 1'b0;   // IF/ID re-presents the dependent instruction
            flush[1] = 1'b1;   // bubble into ID/EX
        end else if (!ihit) begin
            en       = '1;
            en[0]    = 1'b0;
            flush[0] = 1'b1;   // no instruction arrived; push a NOP into IF/ID
        end else begin
            en    = '1;
            pc_en = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_v) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (dreq_v && !dhit) begin
                        state_q  <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (halt_v) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (dhit) begin
                        state_q  <= RUN;
                    end
                end
                HALTED: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_q;

    // Each latch's valid source is the valid bit of the latch upstream of it;
    // IF/ID takes the fetch completion directly.
    logic [NUM_LATCHES-1:0] vsrc;
    assign vsrc = {stage_valid[NUM_LATCHES-2:0], ihit};

    generate
        for (genvar g = 0; g < NUM_LATCHES; g++) begin : g_lat
            pipeline_latch_valid u_valid (
                .CLK     (CLK),
                .nRST    (nRST),
                .en_i    (en[g]),
                .flush_i (flush[g]),
                .src_i   (vsrc[g]),
                .valid_o (stage_valid[g])
            );
        end
    endgenerate

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;
    logic        stall_ev;
    assign stall_ev = run_or_wait && (freeze || lu_take);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (br_take  && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Directed bench for pipeline_latch_ctrl (BR_FLUSH_DEPTH = 2). Each step sets
// inputs just after a rising edge, checks the combinational controls mid
// cycle, then checks the registered valid/halt state just after the edge.
module tb_pipeline_latch_ctrl;
    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, dmem_req, load_use, branch_taken, halt_wb;
    logic [3:0] en, flush, stage_valid;
    logic       pc_en, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [3:0] F = 4'b1111;

    always #5 CLK = ~CLK;

    pipeline_latch_ctrl #(.NUM_LATCHES(4), .BR_FLUSH_DEPTH(2)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmem_req     (dmem_req),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .halt_wb      (halt_wb),
        .en           (en),
        .flush        (flush),
        .pc_en        (pc_en),
        .stage_valid  (stage_valid),
        .halted       (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic dm,
                          input logic lu, input logic br, input logic ht);
        ihit = ih; dhit = dh; dmem_req = dm; load_use = lu; branch_taken = br; halt_wb = ht;
    endtask

    // Entered just after a rising edge with inputs already applied.
    task automatic step(input string tag, input logic [3:0] e_en, input logic [3:0] e_fl,
                        input logic e_pc, input logic [3:0] e_sv, input logic e_h);
        #3;
        chk({tag, ".en"},    {28'd0, en},    {28'd0, e_en});
        chk({tag, ".flush"}, {28'd0, flush}, {28'd0, e_fl});
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e_pc});
        @(posedge CLK);
        #1;
        chk({tag, ".sv"},     {28'd0, stage_valid}, {28'd0, e_sv});
        chk({tag, ".halted"}, {31'd0, halted},      {31'd0, e_h});
    endtask

    initial begin
        nRST = 1'b0;
        set_in(1, 0, 0, 0, 0, 0);
        #6;
        // in reset: controls forced low even with ihit high
        chk("rst.en",     {28'd0, en},          32'd0);
        chk("rst.flush",  {28'd0, flush},       32'd0);
        chk("rst.pc_en",  {31'd0, pc_en},       32'd0);
        chk("rst.sv",     {28'd0, stage_valid}, 32'd0);
        chk("rst.halted", {31'd0, halted},      32'd0);
        nRST = 1'b1;

        // fill; halt_wb ignored while MEM/WB is empty
        set_in(1, 0, 0, 0, 0, 1); step("fill0", F, 4'b0000, 1, 4'b0001, 0);
        set_in(1, 0, 0, 0, 0, 0); step("fill1", F, 4'b0000, 1, 4'b0011, 0);
        step("fill2", F, 4'b0000, 1, 4'b0111, 0);
        step("fill3", F, 4'b0000, 1, 4'b1111, 0);
        step("fill4", F, 4'b0000, 1, 4'b1111, 0);

        // 3-cycle data wait, released by dhit
        set_in(1, 0, 1, 0, 0, 0);
        step("dw0", 4'b0000, 4'b0000, 0, 4'b1111, 0);
        step("dw1", 4'b0000, 4'b0000, 0, 4'b1111, 0);
        step("dw2", 4'b0000, 4'b0000, 0, 4'b1111, 0);
        set_in(1, 1, 1, 0, 0, 0); step("dwrel", F, 4'b0000, 1, 4'b1111, 0);

        // load-use bubble and its drain
        set_in(1, 0, 0, 1, 0, 0); step("lu", 4'b1110, 4'b0010, 0, 4'b1101, 0);
        set_in(1, 0, 0, 0, 0, 0); step("lu_r0", F, 4'b0000, 1, 4'b1011, 0);
        step("lu_r1", F, 4'b0000, 1, 4'b0111, 0);
        step("lu_r2", F, 4'b0000, 1, 4'b1111, 0);

        // fetch miss, then load_use ignored with ID/EX empty
        set_in(0, 0, 0, 0, 0, 0); step("nih", 4'b1110, 4'b0001, 0, 4'b1110, 0);
        set_in(1, 0, 0, 0, 0, 0); step("nih_r0", F, 4'b0000, 1, 4'b1101, 0);
        set_in(1, 0, 0, 1, 0, 0); step("lu_ign", F, 4'b0000, 1, 4'b1011, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r0", F, 4'b0000, 1, 4'b0111, 0);
        step("r1", F, 4'b0000, 1, 4'b1111, 0);

        // branch beats load_use; branch ignored with ID/EX empty
        set_in(1, 0, 0, 1, 1, 0); step("lubr", F, 4'b0011, 1, 4'b1100, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r2", F, 4'b0000, 1, 4'b1001, 0);
        set_in(1, 0, 0, 0, 1, 0); step("br_ign", F, 4'b0000, 1, 4'b0011, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r3", F, 4'b0000, 1, 4'b0111, 0);
        step("r4", F, 4'b0000, 1, 4'b1111, 0);

        // branch without ihit still redirects the PC
        set_in(0, 0, 0, 0, 1, 0); step("br_nih", F, 4'b0011, 1, 4'b1100, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r5", F, 4'b0000, 1, 4'b1001, 0);
        // dmem_req ignored with EX/MEM empty
        set_in(1, 0, 1, 0, 0, 0); step("dm_ign", F, 4'b0000, 1, 4'b0011, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r6", F, 4'b0000, 1, 4'b0111, 0);
        step("r7", F, 4'b0000, 1, 4'b1111, 0);

        // freeze beats branch; dhit cycle falls through to branch
        set_in(1, 0, 1, 0, 1, 0); step("frz_br", 4'b0000, 4'b0000, 0, 4'b1111, 0);
        set_in(1, 1, 1, 0, 1, 0); step("rel_br", F, 4'b0011, 1, 4'b1100, 0);
        set_in(1, 0, 0, 0, 0, 0); step("r8", F, 4'b0000, 1, 4'b1001, 0);
        step("r9",  F, 4'b0000, 1, 4'b0011, 0);
        step("r10", F, 4'b0000, 1, 4'b0111, 0);
        step("r11", F, 4'b0000, 1, 4'b1111, 0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf.stall", stall_cycles, 32'd5);
        chk("perf.flush", flush_count,  32'd3);
`endif

        // halt retires; everything frozen afterwards
        set_in(1, 0, 0, 0, 0, 1); step("halt", F, 4'b0000, 1, 4'b1111, 1);
        set_in(1, 0, 0, 1, 1, 0); step("hold0", 4'b0000, 4'b0000, 0, 4'b1111, 1);
        set_in(1, 1, 1, 0, 1, 1); step("hold1", 4'b0000, 4'b0000, 0, 4'b1111, 1);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf.stall_h", stall_cycles, 32'd5);
        chk("perf.flush_h", flush_count,  32'd3);
`endif

        // reset pulse mid-halt
        set_in(1, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        chk("mrst.en",     {28'd0, en},          32'd0);
        chk("mrst.pc_en",  {31'd0, pc_en},       32'd0);
        chk("mrst.sv",     {28'd0, stage_valid}, 32'd0);
        chk("mrst.halted", {31'd0, halted},      32'd0);
        #1;
        nRST = 1'b1;
        step("post", F, 4'b0000, 1, 4'b0001, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
